jtag_tap_bridge: RTL and testbench

- JTAG front end sitting directly upstream of the core logic block; runs entirely in the clk domain.
- Oversamples the external TCK/TMS/TDI pins and runs the IEEE 1149.1 16-state TAP controller on detected TCK edges.
- Shifts a 4-bit instruction register (IR) and a DEFAULT-wide data register (DR).
- Delivers written words to the core as a one-cycle valid pulse and captures core read data for shift-out.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_tap_bridge_if.sv | 9 +
 rtl/jtag_sync_edge.sv | 30 +++
 rtl/jtag_tap_bridge.sv | 95 +++++++++
 tb/tb_jtag_tap_bridge.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state codes, instruction codes and next-state function for the JTAG bridge
package jtag_pkg;
  localparam int DEF_IR_W = 4;
  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;
  localparam logic [3:0] I_IDCODE = 4'h1, I_WRITE = 4'h2, I_READ = 4'h3, I_BYPASS = 4'hF;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      S_TLR:     return tms ? S_TLR   : S_RTI;
      S_RTI:     return tms ? S_SELDR : S_RTI;
      S_SELDR:   return tms ? S_SELIR : S_CAPDR;
      S_CAPDR:   return tms ? S_EX1DR : S_SHDR;
      S_SHDR:    return tms ? S_EX1DR : S_SHDR;
      S_EX1DR:   return tms ? S_UPDDR : S_PAUSEDR;
      S_PAUSEDR: return tms ? S_EX2DR : S_PAUSEDR;
      S_EX2DR:   return tms ? S_UPDDR : S_SHDR;
      S_UPDDR:   return tms ? S_SELDR : S_RTI;
      S_SELIR:   return tms ? S_TLR   : S_CAPIR;
      S_CAPIR:   return tms ? S_EX1IR : S_SHIR;
      S_SHIR:    return tms ? S_EX1IR : S_SHIR;
      S_EX1IR:   return tms ? S_UPDIR : S_PAUSEIR;
      S_PAUSEIR: return tms ? S_EX2IR : S_PAUSEIR;
      S_EX2IR:   return tms ? S_UPDIR : S_SHIR;
      S_UPDIR:   return tms ? S_SELDR : S_RTI;
      default:   return S_TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_bridge_if.sv
// jtag_tap_bridge_if: JTAG pins plus core-side write/read word signals
interface jtag_tap_bridge_if #(parameter int DEFAULT = 32);
    logic               tck, tms, tdi, tdo, tdo_oe;
    logic [DEFAULT-1:0] wr_data, rd_data;
    logic               wr_valid, rd_strobe;
    logic [3:0]         tap_state;
    modport master(output tck, tms, tdi, rd_data, input tdo, tdo_oe, wr_data, wr_valid, rd_strobe, tap_state);
    modport slave(input tck, tms, tdi, rd_data, output tdo, tdo_oe, wr_data, wr_valid, rd_strobe, tap_state);
endinterface

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: 2-flop synchroniser for tck/tms/tdi with tck rise/fall pulses
module jtag_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_tck,
    input  logic i_tms,
    input  logic i_tdi,
    output logic o_tms,
    output logic o_tdi,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] r_tck;
    logic [1:0] r_tms, r_tdi;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tck <= '0;
            r_tms <= '0;
            r_tdi <= '0;
        end else begin
            r_tck <= {r_tck[1:0], i_tck};
            r_tms <= {r_tms[0], i_tms};
            r_tdi <= {r_tdi[0], i_tdi};
        end
    end
    assign o_tms  = r_tms[1];
    assign o_tdi  = r_tdi[1];
    assign o_rise = r_tck[1] & ~r_tck[2];
    assign o_fall = ~r_tck[1] & r_tck[2];
endmodule

// File: rtl/jtag_tap_bridge.sv
// jtag_tap_bridge: oversampled IEEE 1149.1 TAP with IR/DR shift into the core word interface
// Define IDCODE_VAL_EN to implement the IDCODE instruction and make it the reset IR.
module jtag_tap_bridge import jtag_pkg::*; #(
    parameter int               DEFAULT    = 32,
    parameter int               IR_W       = DEF_IR_W,
    parameter logic [DEFAULT-1:0] IDCODE_VAL = DEFAULT'(32'h1000_0001)
) (
    input logic clk,
    input logic rst,
    jtag_tap_bridge_if.slave j
);
`ifdef IDCODE_VAL_EN
    localparam logic [IR_W-1:0] IR_RST = IR_W'(I_IDCODE);
`else
    localparam logic [IR_W-1:0] IR_RST = IR_W'(I_BYPASS);
`endif
    logic               w_tms, w_tdi, w_rise, w_fall;
    logic               w_write, w_read, w_idcode, w_byp, w_tdo;
    logic [3:0]         r_state, w_next;
    logic [IR_W-1:0]    r_ir, r_ir_sh;
    logic [DEFAULT-1:0] r_dr, r_wr_data;
    logic               r_byp, r_wr_valid, r_rd_strobe, r_tdo, r_tdo_oe;

    jtag_sync_edge u_sync (
        .clk(clk), .rst(rst), .i_tck(j.tck), .i_tms(j.tms), .i_tdi(j.tdi),
        .o_tms(w_tms), .o_tdi(w_tdi), .o_rise(w_rise), .o_fall(w_fall)
    );

    assign w_next  = tap_next(r_state, w_tms);
    assign w_write = r_ir == IR_W'(I_WRITE);
    assign w_read  = r_ir == IR_W'(I_READ);
`ifdef IDCODE_VAL_EN
    assign w_idcode = r_ir == IR_W'(I_IDCODE);
`else
    assign w_idcode = 1'b0;
    logic w_unused_idcode;
    assign w_unused_idcode = ^IDCODE_VAL;
`endif
    // Unknown instruction codes fall back to the 1-bit bypass path
    assign w_byp = !(w_write || w_read || w_idcode);
    assign w_tdo = r_state == S_SHIR ? r_ir_sh[0] : w_byp ? r_byp : r_dr[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_TLR;
            r_ir        <= IR_RST;
            r_ir_sh     <= '0;
            r_dr        <= '0;
            r_byp       <= 1'b0;
            r_wr_data   <= '0;
            r_wr_valid  <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_tdo       <= 1'b0;
            r_tdo_oe    <= 1'b0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_rd_strobe <= 1'b0;
            if (w_fall) begin
                r_tdo    <= w_tdo;
                r_tdo_oe <= r_state == S_SHIR || r_state == S_SHDR;
            end
            if (w_rise) begin
                r_state <= w_next;
                if (r_state == S_TLR) r_ir <= IR_RST;
                if (r_state == S_CAPIR && w_next == S_SHIR) r_ir_sh <= IR_W'(IR_CAPTURE);
                if (r_state == S_SHIR) r_ir_sh <= {w_tdi, r_ir_sh[IR_W-1:1]};
                if (w_next == S_UPDIR) r_ir <= r_ir_sh;
                if (r_state == S_CAPDR && w_next == S_SHDR) begin
                    if (w_byp) r_byp <= 1'b0;
                    if (w_write) r_dr <= r_wr_data;
                    if (w_idcode) r_dr <= IDCODE_VAL;
                    if (w_read) begin
                        r_dr        <= j.rd_data;
                        r_rd_strobe <= 1'b1;
                    end
                end
                if (r_state == S_SHDR) begin
                    if (w_byp) r_byp <= w_tdi;
                    else r_dr <= {w_tdi, r_dr[DEFAULT-1:1]};
                end
                if (w_next == S_UPDDR && w_write) begin
                    r_wr_data  <= r_dr;
                    r_wr_valid <= 1'b1;
                end
            end
        end
    end

    assign j.tdo       = r_tdo;
    assign j.tdo_oe    = r_tdo_oe;
    assign j.wr_data   = r_wr_data;
    assign j.wr_valid  = r_wr_valid;
    assign j.rd_strobe = r_rd_strobe;
    assign j.tap_state = r_state;
endmodule

// File: tb/tb_jtag_tap_bridge.sv
// tb_jtag_tap_bridge: directed vector bench for jtag_tap_bridge driving slow TCK through the pins
module tb_jtag_tap_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0;

    always #5 clk = ~clk;

    jtag_tap_bridge_if #(.DEFAULT(32)) bus ();
    jtag_tap_bridge #(.DEFAULT(32)) dut (.clk(clk), .rst(rst), .j(bus));

    always @(negedge clk) begin
        if (bus.wr_valid) wr_cnt <= wr_cnt + 1;
        if (bus.rd_strobe) rd_cnt <= rd_cnt + 1;
    end

    typedef struct {
        logic [3:0]  ir;
        logic [31:0] rd;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic [31:0] exp_wr;
        int          exp_wv;
        int          exp_rs;
    } vec_t;
    vec_t v[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // host samples tdo while tck is low, just before raising it
    task automatic tick(input logic m, input logic d, output logic o);
        bus.tms = m;
        bus.tdi = d;
        repeat (6) @(posedge clk);
        @(negedge clk);
        o = bus.tdo;
        bus.tck = 1'b1;
        repeat (6) @(posedge clk);
        bus.tck = 1'b0;
    endtask

    task automatic goto_rti();
        logic b;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic ir_scan(input logic [3:0] code, output logic [3:0] cap);
        logic b;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, code[i], b);
            cap[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tdo"}, 32'(bus.tdo), 32'h0);
        check({tag, " tdo_oe"}, 32'(bus.tdo_oe), 32'h0);
        check({tag, " wr_data"}, bus.wr_data, 32'h0);
        check({tag, " wr_valid"}, 32'(bus.wr_valid), 32'h0);
        check({tag, " rd_strobe"}, 32'(bus.rd_strobe), 32'h0);
    endtask

    initial begin
        logic [31:0] dout, exp;
        logic [3:0]  cap;
        logic        b;
        int          w0, r0;
        v[0] = '{4'h2, 32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 1, 0};
        v[1] = '{4'h2, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0};
        v[2] = '{4'h3, 32'h0000_A5A5, 32'hFFFF_FFFF, 32'h0000_A5A5, 32'h1234_5678, 0, 1};
        v[3] = '{4'h7, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1234_5678, 0, 0};
        v[4] = '{4'hF, 32'h0,         32'h0000_0003, 32'h0000_0006, 32'h1234_5678, 0, 0};
`ifdef IDCODE_VAL_EN
        v[5] = '{4'h1, 32'h0,         32'h8000_0001, 32'h1000_0001, 32'h1234_5678, 0, 0};
`else
        v[5] = '{4'h1, 32'h0,         32'h8000_0001, 32'h0000_0002, 32'h1234_5678, 0, 0};
`endif
        v[6] = '{4'h3, 32'hCAFE_F00D, 32'h0,         32'hCAFE_F00D, 32'h1234_5678, 0, 1};
        bus.tck = 1'b0;
        bus.tms = 1'b1;
        bus.tdi = 1'b0;
        bus.rd_data = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset tap_state", 32'(bus.tap_state), 32'hF);
        check_reset_outputs("reset");
        rst = 1'b1;
        goto_rti();
        check("rti tap_state", 32'(bus.tap_state), 32'hC);
        check_reset_outputs("rti");

        // first DR scan after reset hits the reset instruction
`ifdef IDCODE_VAL_EN
        dr_scan(32, 32'h0, dout);
        check("first dr idcode", dout, 32'h1000_0001);
`else
        dr_scan(32, 32'hA5A5_0F0F, dout);
        check("first dr bypass", dout, 32'h4B4A_1E1E);
`endif

        for (int k = 0; k < 7; k++) begin
            bus.rd_data = v[k].rd;
            ir_scan(v[k].ir, cap);
            check($sformatf("v%0d ir capture", k), 32'(cap), 32'h1);
            w0 = wr_cnt;
            r0 = rd_cnt;
            dr_scan(32, v[k].din, dout);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d dr out", k), dout, v[k].exp_dout);
            check($sformatf("v%0d wr_data", k), bus.wr_data, v[k].exp_wr);
            check($sformatf("v%0d wr_valid cycles", k), 32'(wr_cnt - w0), 32'(v[k].exp_wv));
            check($sformatf("v%0d rd_strobe cycles", k), 32'(rd_cnt - r0), 32'(v[k].exp_rs));
            check($sformatf("v%0d tap_state", k), 32'(bus.tap_state), 32'hC);
        end

        ir_scan(4'h7, cap);
        dr_scan(8, 32'hFF, dout);
        check("bypass 8 bit", dout, 32'hFE);

        // five TMS=1 edges from mid-shift reach TLR and restore the reset IR
        ir_scan(4'h2, cap);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, b);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, b);
        repeat (4) @(negedge clk);
        check("tms5 tap_state", 32'(bus.tap_state), 32'hF);
        tick(1'b0, 1'b0, b);
        dr_scan(8, 32'hFF, dout);
`ifdef IDCODE_VAL_EN
        exp = 32'h01;
`else
        exp = 32'hFE;
`endif
        check("tlr forces ir", dout, exp);

        // reset mid WRITE scan
        ir_scan(4'h2, cap);
        w0 = wr_cnt;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, b);
        repeat (6) @(negedge clk);
        check("midscan tap_state", 32'(bus.tap_state), 32'h2);
        check("midscan tdo_oe", 32'(bus.tdo_oe), 32'h1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort tap_state", 32'(bus.tap_state), 32'hF);
        check_reset_outputs("abort");
        rst = 1'b1;
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, b);
        repeat (4) @(negedge clk);
        check("abort wr_data", bus.wr_data, 32'h0);
        check("abort wr_valid cycles", 32'(wr_cnt - w0), 32'h0);
        check("abort tap_state after", 32'(bus.tap_state), 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
